// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the staged-reset/wait controller and its user:
// reset/wait requests in, staged resets, status and the wait service out.
interface rst_seq_ctrl_if #(
  parameter int WAIT_W = 16,
  parameter int CNT_W  = 8
);
  logic              sw_rst_req;
  logic              wait_start;
  logic [WAIT_W-1:0] wait_num;
  logic              core_rst;
  logic              periph_rst;
  logic              rst_done;
  logic              wait_busy;
  logic              wait_done;
  logic [CNT_W-1:0]  rst_count;

  modport master (
    output sw_rst_req, wait_start, wait_num,
    input  core_rst, periph_rst, rst_done, wait_busy, wait_done, rst_count
  );

  modport slave (
    input  sw_rst_req, wait_start, wait_num,
    output core_rst, periph_rst, rst_done, wait_busy, wait_done, rst_count
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer for the SPI datapath (core released before peripheral)
// plus a timed cycle-wait service that only runs once the sequence has completed.
module rst_seq_ctrl #(
  parameter int HOLD_CYCLES = 5,
  parameter int STAGE_GAP   = 2,
  parameter int WAIT_W      = 16,
  parameter int CNT_W       = 8
) (
  input logic           clk,
  input logic           rst,
  rst_seq_ctrl_if.slave bus
);

  localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    ASSERT,
    REL_CORE,
    RUN
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WAIT_W-1:0] wcnt;
  logic              core_rst;
  logic              periph_rst;
  logic              rst_done;
  logic              wait_busy;
  logic              wait_done;
  logic [CNT_W-1:0]  rst_count;

  // A software request outranks the sequencer and the wait service alike: it
  // restarts the hold phase and silently aborts any wait in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ASSERT;
      cnt        <= '0;
      wcnt       <= '0;
      core_rst   <= 1'b1;
      periph_rst <= 1'b1;
      rst_done   <= 1'b0;
      wait_busy  <= 1'b0;
      wait_done  <= 1'b0;
      rst_count  <= '0;
    end else begin
      wait_done <= 1'b0;
      if (bus.sw_rst_req) begin
        state      <= ASSERT;
        cnt        <= '0;
        core_rst   <= 1'b1;
        periph_rst <= 1'b1;
        rst_done   <= 1'b0;
        wait_busy  <= 1'b0;
        if (state != ASSERT && rst_count != {CNT_W{1'b1}})
          rst_count <= rst_count + 1'b1;
      end else begin
        case (state)
          ASSERT: begin
            if (cnt == CW'(HOLD_CYCLES - 1)) begin
              state    <= REL_CORE;
              cnt      <= '0;
              core_rst <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REL_CORE: begin
            if (cnt == CW'(STAGE_GAP - 1)) begin
              state      <= RUN;
              cnt        <= '0;
              periph_rst <= 1'b0;
              rst_done   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase

        // wcnt holds the edges still to go; the done pulse fires on the last one.
        if (wait_busy) begin
          if (wcnt == WAIT_W'(1)) begin
            wait_busy <= 1'b0;
            wait_done <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end else if (bus.wait_start && rst_done) begin
          if (bus.wait_num == '0) begin
            wait_done <= 1'b1;
          end else begin
            wait_busy <= 1'b1;
            wcnt      <= bus.wait_num;
          end
        end
      end
    end
  end

  assign bus.core_rst   = core_rst;
  assign bus.periph_rst = periph_rst;
  assign bus.rst_done   = rst_done;
  assign bus.wait_busy  = wait_busy;
  assign bus.wait_done  = wait_done;
  assign bus.rst_count  = rst_count;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: two instances (8-bit and 2-bit rst_count) share stimulus
// and are checked every cycle against an edge-counting model plus literal checks.
module tb_rst_seq_ctrl;
  localparam int HOLD = 5;
  localparam int GAP  = 2;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rst_seq_ctrl_if #(.WAIT_W(16), .CNT_W(8)) bus8 ();
  rst_seq_ctrl_if #(.WAIT_W(16), .CNT_W(2)) bus2 ();

  rst_seq_ctrl #(.HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .WAIT_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  rst_seq_ctrl #(.HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .WAIT_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: resets follow purely from edges elapsed since the last rst/sw request;
  // a wait is an absolute edge number at which the done pulse is due.
  int      since = 0;
  longint  edge_n = 0;
  longint  done_edge = 0;
  bit      m_busy = 0;
  bit      m_wdone = 0;
  int      m_cnt8 = 0;
  int      m_cnt2 = 0;
  bit      model_valid = 0;
  bit      seen_done = 0;

  always @(posedge clk) begin
    bit prev_core;
    bit prev_done;
    edge_n++;
    prev_core = (since < HOLD);
    prev_done = (since >= HOLD + GAP);
    m_wdone = 0;
    if (rst) begin
      model_valid = 1;
      since  = 0;
      m_busy = 0;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (bus8.sw_rst_req) begin
      if (!prev_core) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      since  = 0;
      m_busy = 0;
    end else begin
      if (since < HOLD + GAP) since++;
      if (m_busy) begin
        if (edge_n == done_edge) begin
          m_busy  = 0;
          m_wdone = 1;
        end
      end else if (bus8.wait_start && prev_done) begin
        if (bus8.wait_num == 0) m_wdone = 1;
        else begin
          m_busy    = 1;
          done_edge = edge_n + longint'(bus8.wait_num);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("core_rst",   32'(bus8.core_rst),   32'(since < HOLD));
      checkOutput("periph_rst", 32'(bus8.periph_rst), 32'(since < HOLD + GAP));
      checkOutput("rst_done",   32'(bus8.rst_done),   32'(since >= HOLD + GAP));
      checkOutput("wait_busy",  32'(bus8.wait_busy),  32'(m_busy));
      checkOutput("wait_done",  32'(bus8.wait_done),  32'(m_wdone));
      checkOutput("rst_count8", 32'(bus8.rst_count),  32'(m_cnt8));
      checkOutput("core_rst2",  32'(bus2.core_rst),   32'(since < HOLD));
      checkOutput("wait_done2", 32'(bus2.wait_done),  32'(m_wdone));
      checkOutput("rst_count2", 32'(bus2.rst_count),  32'(m_cnt2));
      if (bus8.wait_done) seen_done = 1;
    end
  end

  task automatic applyStimulus(input logic r, input logic sw, input logic ws, input logic [15:0] wn);
    rst             = r;
    bus8.sw_rst_req = sw;
    bus8.wait_start = ws;
    bus8.wait_num   = wn;
    bus2.sw_rst_req = sw;
    bus2.wait_start = ws;
    bus2.wait_num   = wn;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0);
    cycles(3);
    checkOutput("por_core_in_rst", 32'(bus8.core_rst), 32'd1);
    checkOutput("por_done_in_rst", 32'(bus8.rst_done), 32'd0);

    // Power-on release timing.
    applyStimulus(0, 0, 0, 0);
    cycles(4);
    checkOutput("por_core_edge4", 32'(bus8.core_rst), 32'd1);
    cycles(1);
    checkOutput("por_core_edge5", 32'(bus8.core_rst), 32'd0);
    checkOutput("por_periph_edge5", 32'(bus8.periph_rst), 32'd1);
    cycles(1);
    checkOutput("por_done_edge6", 32'(bus8.rst_done), 32'd0);
    cycles(1);
    checkOutput("por_periph_edge7", 32'(bus8.periph_rst), 32'd0);
    checkOutput("por_done_edge7", 32'(bus8.rst_done), 32'd1);
    checkOutput("por_count", 32'(bus8.rst_count), 32'd0);

    // Single-cycle software reset from RUN.
    applyStimulus(0, 1, 0, 0);
    cycles(1);
    checkOutput("sw_core_high", 32'(bus8.core_rst), 32'd1);
    checkOutput("sw_count1", 32'(bus8.rst_count), 32'd1);
    applyStimulus(0, 0, 0, 0);
    cycles(4);
    checkOutput("sw_core_still", 32'(bus8.core_rst), 32'd1);
    cycles(1);
    checkOutput("sw_core_fall", 32'(bus8.core_rst), 32'd0);
    cycles(2);
    checkOutput("sw_done", 32'(bus8.rst_done), 32'd1);

    // Request landing in REL_CORE restarts the whole sequence.
    applyStimulus(0, 1, 0, 0);
    cycles(1);
    applyStimulus(0, 0, 0, 0);
    cycles(5);
    checkOutput("relc_core_low", 32'(bus8.core_rst), 32'd0);
    applyStimulus(0, 1, 0, 0);
    cycles(1);
    checkOutput("relc_core_reassert", 32'(bus8.core_rst), 32'd1);
    applyStimulus(0, 0, 0, 0);
    cycles(6);
    checkOutput("relc_periph_held", 32'(bus8.periph_rst), 32'd1);
    cycles(1);
    checkOutput("relc_done", 32'(bus8.rst_done), 32'd1);
    checkOutput("relc_count3", 32'(bus8.rst_count), 32'd3);

    // Timed wait of 3, with a second start ignored while busy.
    applyStimulus(0, 0, 1, 16'd3);
    cycles(1);
    checkOutput("w3_busy_e0", 32'(bus8.wait_busy), 32'd1);
    applyStimulus(0, 0, 1, 16'd7);
    cycles(1);
    applyStimulus(0, 0, 0, 0);
    cycles(1);
    checkOutput("w3_done_e2", 32'(bus8.wait_done), 32'd0);
    cycles(1);
    checkOutput("w3_done_e3", 32'(bus8.wait_done), 32'd1);
    checkOutput("w3_busy_e3", 32'(bus8.wait_busy), 32'd0);
    cycles(1);
    checkOutput("w3_ignored", 32'(bus8.wait_busy), 32'd0);

    // Zero-length wait.
    applyStimulus(0, 0, 1, 16'd0);
    cycles(1);
    checkOutput("w0_done", 32'(bus8.wait_done), 32'd1);
    checkOutput("w0_busy", 32'(bus8.wait_busy), 32'd0);
    applyStimulus(0, 0, 0, 0);
    cycles(1);
    checkOutput("w0_pulse_end", 32'(bus8.wait_done), 32'd0);

    // Wait of 10 aborted by a software reset at E0+4; a start during the sequence is ignored.
    applyStimulus(0, 0, 1, 16'd10);
    cycles(1);
    seen_done = 0;
    applyStimulus(0, 0, 0, 0);
    cycles(3);
    applyStimulus(0, 1, 0, 0);
    cycles(1);
    checkOutput("abort_busy", 32'(bus8.wait_busy), 32'd0);
    applyStimulus(0, 0, 1, 16'd2);
    cycles(1);
    applyStimulus(0, 0, 0, 0);
    cycles(14);
    checkOutput("abort_no_done", 32'(seen_done), 32'd0);
    checkOutput("abort_count4", 32'(bus8.rst_count), 32'd4);

    // Saturation of the 2-bit counter.
    checkOutput("sat2_after4", 32'(bus2.rst_count), 32'd3);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0);
      cycles(1);
      applyStimulus(0, 0, 0, 0);
      cycles(HOLD + GAP);
    end
    checkOutput("sat2_final", 32'(bus2.rst_count), 32'd3);
    checkOutput("cnt8_final", 32'(bus8.rst_count), 32'd6);

    // Held request stretches ASSERT without counting again.
    applyStimulus(0, 1, 0, 0);
    cycles(4);
    checkOutput("held_count7", 32'(bus8.rst_count), 32'd7);
    applyStimulus(0, 0, 0, 0);
    cycles(HOLD);
    checkOutput("held_core_fall", 32'(bus8.core_rst), 32'd0);

    // Global reset mid-ASSERT clears the counters.
    applyStimulus(0, 1, 0, 0);
    cycles(1);
    applyStimulus(0, 0, 0, 0);
    cycles(2);
    applyStimulus(1, 0, 0, 0);
    cycles(1);
    checkOutput("rst_clears_count", 32'(bus8.rst_count), 32'd0);
    checkOutput("rst_clears_count2", 32'(bus2.rst_count), 32'd0);
    applyStimulus(0, 0, 0, 0);
    cycles(HOLD + GAP);
    checkOutput("rst_redone", 32'(bus8.rst_done), 32'd1);

    applyStimulus(0, 0, 1, 16'd1);
    cycles(1);
    applyStimulus(0, 0, 0, 0);
    cycles(1);
    checkOutput("w1_done", 32'(bus8.wait_done), 32'd1);
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
